iso_sprite_mover: RTL and testbench

- Parametrised successor to the free-movement sprite mover. Steps a sprite diagonally across the isometric screen at a programmable tick rate.
- Bounds-checks each step against a configurable playfield and applies any of N configurable teleport portals.
- Sequences the background-erase and character-draw requests to the sprite drawer FSM.
- Sits between the input decoder (move/dir) and the sprite drawer.

---
 rtl/iso_sprite_mover_if.sv | 27 ++
 rtl/iso_sprite_mover.sv | 161 ++++++++++++++++
 tb/tb_iso_sprite_mover.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iso_sprite_mover_if.sv
// Handshake bundle between the input decoder / sprite drawer and the isometric sprite mover.
interface iso_sprite_mover_if #(
    parameter int X_W = 9,
    parameter int Y_W = 8
);
    logic           move;
    logic [1:0]     dir;
    logic           doneBG;
    logic           doneChar;
    logic [X_W-1:0] xCoordinate;
    logic [Y_W-1:0] yCoordinate;
    logic           drawBG;
    logic           drawChar;
    logic           busy;
    logic           blocked;
    logic           teleported;

    modport master (
        output move, dir, doneBG, doneChar,
        input  xCoordinate, yCoordinate, drawBG, drawChar, busy, blocked, teleported
    );

    modport slave (
        input  move, dir, doneBG, doneChar,
        output xCoordinate, yCoordinate, drawBG, drawChar, busy, blocked, teleported
    );
endinterface

// File: rtl/iso_sprite_mover.sv
// Steps a sprite diagonally on a tick, bounds-checks and portals each step,
// then sequences background-erase and character-draw requests to the drawer.
module iso_sprite_mover #(
    parameter int X_W         = 9,
    parameter int Y_W         = 8,
    parameter int X_MIN       = 1,
    parameter int X_MAX       = 320,
    parameter int Y_MIN       = 1,
    parameter int Y_MAX       = 240,
    parameter int STEP        = 1,
    parameter int START_X     = 95,
    parameter int START_Y     = 221,
    parameter int TICK_DIV    = 6250000,
    parameter int NUM_PORTALS = 1,
    parameter logic [NUM_PORTALS*X_W-1:0] PORTAL_SRC_X = 9'd120,
    parameter logic [NUM_PORTALS*Y_W-1:0] PORTAL_SRC_Y = 8'd196,
    parameter logic [NUM_PORTALS*X_W-1:0] PORTAL_DST_X = 9'd126,
    parameter logic [NUM_PORTALS*Y_W-1:0] PORTAL_DST_Y = 8'd68
) (
    input logic                clock,
    input logic                reset,
    iso_sprite_mover_if.slave  bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] ERASE     = 3'd2;
    localparam logic [2:0] WAIT_BG   = 3'd3;
    localparam logic [2:0] UPDATE    = 3'd4;
    localparam logic [2:0] DRAW      = 3'd5;
    localparam logic [2:0] WAIT_CHAR = 3'd6;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic signed [X_W:0] X_STEP = (X_W+1)'(STEP);
    localparam logic signed [X_W:0] X_LO   = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] X_HI   = (X_W+1)'(X_MAX);
    localparam logic signed [Y_W:0] Y_STEP = (Y_W+1)'(STEP);
    localparam logic signed [Y_W:0] Y_LO   = (Y_W+1)'(Y_MIN);
    localparam logic signed [Y_W:0] Y_HI   = (Y_W+1)'(Y_MAX);

    logic [2:0]       state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [1:0]       dir_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [X_W-1:0]   nx_q;
    logic [Y_W-1:0]   ny_q;
    logic             hit_q;
    logic             blocked_q;
    logic             teleported_q;

    logic signed [X_W:0] cur_x;
    logic signed [Y_W:0] cur_y;
    logic signed [X_W:0] cand_x;
    logic signed [Y_W:0] cand_y;
    logic                legal;
    logic                hit;
    logic [X_W-1:0]      hit_x;
    logic [Y_W-1:0]      hit_y;

    // Free-running tick divider; the FSM only samples it, never stalls it.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clock) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // One extra sign bit lets a step below zero show up as a negative candidate.
    assign cur_x  = signed'({1'b0, x_q});
    assign cur_y  = signed'({1'b0, y_q});
    assign cand_x = dir_q[0] ? (cur_x - X_STEP) : (cur_x + X_STEP);
    assign cand_y = dir_q[1] ? (cur_y - Y_STEP) : (cur_y + Y_STEP);
    assign legal  = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                    (cand_y >= Y_LO) && (cand_y <= Y_HI);

    always_comb begin
        hit   = 1'b0;
        hit_x = '0;
        hit_y = '0;
        for (int unsigned i = 0; i < NUM_PORTALS; i++) begin
            if (!hit &&
                cand_x == signed'({1'b0, PORTAL_SRC_X[i*X_W +: X_W]}) &&
                cand_y == signed'({1'b0, PORTAL_SRC_Y[i*Y_W +: Y_W]})) begin
                hit   = 1'b1;
                hit_x = PORTAL_DST_X[i*X_W +: X_W];
                hit_y = PORTAL_DST_Y[i*Y_W +: Y_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            dir_q        <= '0;
            x_q          <= X_W'(START_X);
            y_q          <= Y_W'(START_Y);
            nx_q         <= '0;
            ny_q         <= '0;
            hit_q        <= 1'b0;
            blocked_q    <= 1'b0;
            teleported_q <= 1'b0;
        end else begin
            blocked_q    <= 1'b0;
            teleported_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.move && tick) begin
                        dir_q <= bus.dir;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    nx_q  <= hit ? hit_x : cand_x[X_W-1:0];
                    ny_q  <= hit ? hit_y : cand_y[Y_W-1:0];
                    hit_q <= hit;
                    if (legal) begin
                        state <= ERASE;
                    end else begin
                        blocked_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERASE: state <= WAIT_BG;
                WAIT_BG: begin
                    if (bus.doneBG) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    x_q          <= nx_q;
                    y_q          <= ny_q;
                    teleported_q <= hit_q;
                    state        <= DRAW;
                end
                DRAW: state <= WAIT_CHAR;
                WAIT_CHAR: begin
                    if (bus.doneChar) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.xCoordinate = x_q;
    assign bus.yCoordinate = y_q;
    assign bus.drawBG      = (state == ERASE) || (state == WAIT_BG);
    assign bus.drawChar    = (state == DRAW)  || (state == WAIT_CHAR);
    assign bus.busy        = (state != IDLE);
    assign bus.blocked     = blocked_q;
    assign bus.teleported  = teleported_q;

endmodule

// File: tb/tb_iso_sprite_mover.sv
// Bench for iso_sprite_mover: five differently configured instances share stimulus; one is observed at a time.
module tb_iso_sprite_mover;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       move = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       doneBG = 1'b0;
    logic       doneChar = 1'b0;
    logic       resp_en = 1'b1;
    int         sel = 0;

    int checks = 0;
    int passes = 0;
    int mx, my;

    always #5 clock = ~clock;

    iso_sprite_mover_if #(.X_W(9), .Y_W(8)) bus0 ();
    iso_sprite_mover_if #(.X_W(9), .Y_W(8)) bus1 ();
    iso_sprite_mover_if #(.X_W(9), .Y_W(8)) bus2 ();
    iso_sprite_mover_if #(.X_W(9), .Y_W(8)) bus3 ();
    iso_sprite_mover_if #(.X_W(9), .Y_W(8)) bus4 ();

    assign bus0.move = move; assign bus0.dir = dir; assign bus0.doneBG = doneBG; assign bus0.doneChar = doneChar;
    assign bus1.move = move; assign bus1.dir = dir; assign bus1.doneBG = doneBG; assign bus1.doneChar = doneChar;
    assign bus2.move = move; assign bus2.dir = dir; assign bus2.doneBG = doneBG; assign bus2.doneChar = doneChar;
    assign bus3.move = move; assign bus3.dir = dir; assign bus3.doneBG = doneBG; assign bus3.doneChar = doneChar;
    assign bus4.move = move; assign bus4.dir = dir; assign bus4.doneBG = doneBG; assign bus4.doneChar = doneChar;

    iso_sprite_mover #(.TICK_DIV(4)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    iso_sprite_mover #(.TICK_DIV(1), .START_X(2), .START_Y(2)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    iso_sprite_mover #(.TICK_DIV(1), .START_X(320), .START_Y(100)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
    iso_sprite_mover #(.TICK_DIV(1), .START_X(119), .START_Y(197)) dut3 (.clock(clock), .reset(reset), .bus(bus3));
    iso_sprite_mover #(
        .TICK_DIV(1), .START_X(49), .START_Y(49), .NUM_PORTALS(2),
        .PORTAL_SRC_X({9'd50, 9'd50}), .PORTAL_SRC_Y({8'd50, 8'd50}),
        .PORTAL_DST_X({9'd20, 9'd10}), .PORTAL_DST_Y({8'd20, 8'd10})
    ) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    logic [8:0] ox;
    logic [7:0] oy;
    logic       obg, och, obusy, oblk, otel;

    always_comb begin
        case (sel)
            1:       {ox, oy, obg, och, obusy, oblk, otel} = {bus1.xCoordinate, bus1.yCoordinate, bus1.drawBG, bus1.drawChar, bus1.busy, bus1.blocked, bus1.teleported};
            2:       {ox, oy, obg, och, obusy, oblk, otel} = {bus2.xCoordinate, bus2.yCoordinate, bus2.drawBG, bus2.drawChar, bus2.busy, bus2.blocked, bus2.teleported};
            3:       {ox, oy, obg, och, obusy, oblk, otel} = {bus3.xCoordinate, bus3.yCoordinate, bus3.drawBG, bus3.drawChar, bus3.busy, bus3.blocked, bus3.teleported};
            4:       {ox, oy, obg, och, obusy, oblk, otel} = {bus4.xCoordinate, bus4.yCoordinate, bus4.drawBG, bus4.drawChar, bus4.busy, bus4.blocked, bus4.teleported};
            default: {ox, oy, obg, och, obusy, oblk, otel} = {bus0.xCoordinate, bus0.yCoordinate, bus0.drawBG, bus0.drawChar, bus0.busy, bus0.blocked, bus0.teleported};
        endcase
    end

    // Running event counters on the observed instance; steps look at deltas.
    int blk_cnt = 0, tel_cnt = 0, bg_cnt = 0, ch_cnt = 0, overlap = 0;
    always @(negedge clock) begin
        if (oblk) blk_cnt++;
        if (otel) tel_cnt++;
        if (obg) bg_cnt++;
        if (och) ch_cnt++;
        if (obg && och) overlap++;
    end

    // Drawer stand-in: acknowledge each request two cycles after it appears.
    int bg_age = 0, ch_age = 0;
    always @(negedge clock) begin
        doneBG = 1'b0;
        doneChar = 1'b0;
        if (resp_en && obg) begin
            bg_age++;
            if (bg_age == 2) doneBG = 1'b1;
        end else begin
            bg_age = 0;
        end
        if (resp_en && och) begin
            ch_age++;
            if (ch_age == 2) doneChar = 1'b1;
        end else begin
            ch_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic void start_pos(input int cfg, output int x, output int y);
        case (cfg)
            1:       begin x = 2;   y = 2;   end
            2:       begin x = 320; y = 100; end
            3:       begin x = 119; y = 197; end
            4:       begin x = 49;  y = 49;  end
            default: begin x = 95;  y = 221; end
        endcase
    endfunction

    // Reference: diagonal step, inclusive playfield, first matching portal wins.
    function automatic void model_step(input int x, input int y, input int d, input int cfg,
                                       output int nx, output int ny, output int blk, output int tel);
        int cx, cy, np;
        int psx[2], psy[2], pdx[2], pdy[2];
        cx = ((d & 1) != 0) ? x - 1 : x + 1;
        cy = ((d & 2) != 0) ? y - 1 : y + 1;
        if (cfg == 4) begin
            np = 2;
            psx = '{50, 50}; psy = '{50, 50}; pdx = '{10, 20}; pdy = '{10, 20};
        end else begin
            np = 1;
            psx = '{120, 0}; psy = '{196, 0}; pdx = '{126, 0}; pdy = '{68, 0};
        end
        nx = x; ny = y; blk = 0; tel = 0;
        if (cx < 1 || cx > 320 || cy < 1 || cy > 240) begin
            blk = 1;
        end else begin
            nx = cx; ny = cy;
            for (int i = 0; i < np; i++) begin
                if (tel == 0 && cx == psx[i] && cy == psy[i]) begin
                    nx = pdx[i]; ny = pdy[i]; tel = 1;
                end
            end
        end
    endfunction

    task automatic do_reset(input int s);
        sel = s;
        @(negedge clock);
        reset = 1'b1;
        move = 1'b0;
        repeat (2) @(negedge clock);
        start_pos(s, mx, my);
        check("rst_x", ox, mx);
        check("rst_y", oy, my);
        check("rst_busy", obusy, 0);
        check("rst_req", {obg, och, oblk, otel}, 0);
        reset = 1'b0;
    endtask

    // lows >= 0: busy must stay low for exactly that many cycles after move rises.
    task automatic run_step(input logic [1:0] d, input int lows);
        int ex, ey, eb, et, b0, t0, g0, c0, n;
        model_step(mx, my, int'(d), sel, ex, ey, eb, et);
        b0 = blk_cnt; t0 = tel_cnt; g0 = bg_cnt; c0 = ch_cnt;
        move = 1'b1;
        dir = d;
        if (lows >= 0) begin
            for (int i = 0; i < lows; i++) begin
                @(negedge clock);
                check("idle_wait_tick", obusy, 0);
            end
            @(negedge clock);
        end else begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!obusy && n < 50);
        end
        move = 1'b0;
        check("accept", obusy, 1);
        n = 0;
        while (obusy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("complete", obusy, 0);
        repeat (2) @(negedge clock);
        check("x", ox, ex);
        check("y", oy, ey);
        check("blocked_pulses", blk_cnt - b0, eb);
        check("teleport_pulses", tel_cnt - t0, et);
        check("drawbg_seen", (bg_cnt != g0), (eb == 0));
        check("drawchar_seen", (ch_cnt != c0), (eb == 0));
        mx = ex;
        my = ey;
    endtask

    initial begin
        logic [1:0] rd;
        int n;

        // Basic move on the divided tick: tick fires 3 cycles after reset releases.
        do_reset(0);
        run_step(2'd0, 3);
        run_step(2'd3, -1);
        run_step(2'd1, -1);

        // Lower-left corner.
        do_reset(1);
        run_step(2'd3, 0);
        run_step(2'd3, 0);
        for (int i = 0; i < 20; i++) begin
            rd = 2'($urandom_range(0, 3));
            run_step(rd, 0);
        end

        // Right edge.
        do_reset(2);
        run_step(2'd0, 0);
        run_step(2'd1, 0);
        for (int i = 0; i < 15; i++) begin
            rd = 2'($urandom_range(0, 3));
            run_step(rd, 0);
        end

        // Default portal, then wander.
        do_reset(3);
        run_step(2'd2, 0);
        for (int i = 0; i < 20; i++) begin
            rd = 2'($urandom_range(0, 3));
            run_step(rd, 0);
        end

        // Two portals sharing a source: lowest index wins.
        do_reset(4);
        run_step(2'd0, 0);

        // Stalled drawer, busy inputs ignored, then reset aborts the handshake.
        do_reset(0);
        resp_en = 1'b0;
        move = 1'b1;
        dir = 2'd0;
        n = 0;
        while (!obg && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("stall_drawbg_up", obg, 1);
        repeat (100) begin
            @(negedge clock);
            move = 1'($urandom_range(0, 1));
            dir = 2'($urandom_range(0, 3));
        end
        check("stall_drawbg_held", obg, 1);
        check("stall_busy", obusy, 1);
        check("stall_x", ox, 95);
        check("stall_y", oy, 221);
        reset = 1'b1;
        move = 1'b0;
        @(negedge clock);
        check("abort_x", ox, 95);
        check("abort_y", oy, 221);
        check("abort_busy", obusy, 0);
        check("abort_req", {obg, och, oblk, otel}, 0);
        reset = 1'b0;
        resp_en = 1'b1;
        repeat (2) @(negedge clock);

        check("no_overlap", overlap, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
